// File: rtl/wf68k30l_data_arbiter.sv
// wf68k30l_data_arbiter: fixed-priority data-bus arbiter with an operand-fetch
// starvation guard and bus locking across read-modify-write sequences.
module wf68k30l_data_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  REQ,
    input  logic [2:0]  RW,
    input  logic [2:0]  LOCK,
    input  logic [95:0] ADR_I,
    input  logic [5:0]  SIZE_I,
    input  logic [95:0] DATA_I,
    output logic [2:0]  ACK,
    output logic [2:0]  ERR,
    output logic [31:0] DATA_O,
    output logic [1:0]  GNT_ID,
    output logic        BUS_REQ,
    output logic        BUS_RW,
    output logic        BUS_LOCK,
    output logic [31:0] BUS_ADR,
    output logic [1:0]  BUS_SIZE,
    output logic [31:0] BUS_DATA_OUT,
    input  logic [31:0] BUS_DATA_IN,
    input  logic        BUS_RDY,
    input  logic        BUS_ERR
);
    typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [2:0]  ack_q, ack_d, err_q, err_d, req_eff;
    logic [31:0] data_o_q, data_o_d, adr_q, adr_d, wdat_q, wdat_d;
    logic [1:0]  gnt_q, gnt_d, size_q, size_d, win, sel;
    logic        req_q, req_d, rw_q, rw_d, lock_q, lock_d, grant;
    logic [3:0]  starve_q, starve_d;

    // A requester's request is still up during its own ACK/ERR cycle.
    assign req_eff = REQ & ~(ack_q | err_q);
    assign win     = (starve_q >= LIMIT && req_eff[2]) ? 2'd2 :
                     req_eff[0] ? 2'd0 : req_eff[1] ? 2'd1 : 2'd2;
    assign sel     = (state_q == LOCKED) ? gnt_q : win;
    assign grant   = (state_q == IDLE && |req_eff) || (state_q == LOCKED && req_eff[gnt_q]);

    always_comb begin
        state_d  = state_q;
        ack_d    = '0;
        err_d    = '0;
        data_o_d = data_o_q;
        gnt_d    = gnt_q;
        rw_d     = rw_q;
        lock_d   = lock_q;
        adr_d    = adr_q;
        size_d   = size_q;
        wdat_d   = wdat_q;
        if (grant) begin
            state_d = BUSY;
            gnt_d   = sel;
            rw_d    = RW[sel];
            lock_d  = lock_q | LOCK[sel];
            adr_d   = ADR_I[32*sel +: 32];
            size_d  = SIZE_I[2*sel +: 2];
            wdat_d  = DATA_I[32*sel +: 32];
        end else if (state_q == BUSY && BUS_ERR) begin
            state_d      = IDLE;
            err_d[gnt_q] = 1'b1;
            lock_d       = 1'b0;
        end else if (state_q == BUSY && BUS_RDY) begin
            state_d      = LOCK[gnt_q] ? LOCKED : IDLE;
            ack_d[gnt_q] = 1'b1;
            data_o_d     = BUS_DATA_IN;
            lock_d       = LOCK[gnt_q];
        end
        req_d    = (state_d == BUSY);
        starve_d = !REQ[2] ? 4'd0 : !grant ? starve_q : (sel == 2'd2) ? 4'd0 :
                   (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            ack_q    <= '0;
            err_q    <= '0;
            data_o_q <= '0;
            gnt_q    <= '0;
            req_q    <= 1'b0;
            rw_q     <= 1'b0;
            lock_q   <= 1'b0;
            adr_q    <= '0;
            size_q   <= '0;
            wdat_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            data_o_q <= data_o_d;
            gnt_q    <= gnt_d;
            req_q    <= req_d;
            rw_q     <= rw_d;
            lock_q   <= lock_d;
            adr_q    <= adr_d;
            size_q   <= size_d;
            wdat_q   <= wdat_d;
            starve_q <= starve_d;
        end
    end

    assign ACK          = ack_q;
    assign ERR          = err_q;
    assign DATA_O       = data_o_q;
    assign GNT_ID       = gnt_q;
    assign BUS_REQ      = req_q;
    assign BUS_RW       = rw_q;
    assign BUS_LOCK     = lock_q;
    assign BUS_ADR      = adr_q;
    assign BUS_SIZE     = size_q;
    assign BUS_DATA_OUT = wdat_q;
endmodule

// File: tb/tb_wf68k30l_data_arbiter.sv
// tb_wf68k30l_data_arbiter: scoreboard bench with requester and bus-slave models
// for the data-bus arbiter.
module tb_wf68k30l_data_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, bus_req, bus_rw, bus_lock, bus_rdy, bus_err;
    logic [2:0]  req, rw, lock, ack, err;
    logic [95:0] adr_i, data_i;
    logic [5:0]  size_i;
    logic [31:0] data_o, bus_adr, bus_data_out, bus_data_in;
    logic [1:0]  gnt_id, bus_size;

    wf68k30l_data_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(clk), .RESET(reset), .REQ(req), .RW(rw), .LOCK(lock),
        .ADR_I(adr_i), .SIZE_I(size_i), .DATA_I(data_i),
        .ACK(ack), .ERR(err), .DATA_O(data_o), .GNT_ID(gnt_id),
        .BUS_REQ(bus_req), .BUS_RW(bus_rw), .BUS_LOCK(bus_lock),
        .BUS_ADR(bus_adr), .BUS_SIZE(bus_size), .BUS_DATA_OUT(bus_data_out),
        .BUS_DATA_IN(bus_data_in), .BUS_RDY(bus_rdy), .BUS_ERR(bus_err)
    );

    typedef struct {logic rw, lk; logic [31:0] adr, wd; logic [1:0] sz;} op_t;
    typedef struct {logic [1:0] id; logic rw, lk, err; logic [31:0] adr, wd, rd; logic [1:0] sz;} exp_t;

    op_t         ops [3][8];
    int          nops [3];
    int          pos [3];
    exp_t        exp_q [$];
    int          n_chk = 0, n_fail = 0, wait_n = 1, bus_cnt = 0, low_run = 0;
    logic        err_pend = 0, use_fixed = 0, gap_chk = 0, seen_req = 0, prev_req = 0;
    logic        last_rw = 0, last_lock = 0;
    logic [31:0] fixed_data = 0, last_adr = 0, last_wd = 0;
    logic [1:0]  last_sz = 0;

    function automatic logic [31:0] mix(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    function automatic logic [31:0] adr_of(input int id, input int k);
        return 32'h4000 + 32'(id) * 32'h100 + 32'(k) * 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    task automatic load(input int i);
        if (pos[i] < nops[i]) begin
            req[i]              = 1'b1;
            rw[i]               = ops[i][pos[i]].rw;
            lock[i]             = ops[i][pos[i]].lk;
            adr_i[32*i +: 32]   = ops[i][pos[i]].adr;
            data_i[32*i +: 32]  = ops[i][pos[i]].wd;
            size_i[2*i +: 2]    = ops[i][pos[i]].sz;
        end else begin
            req[i]  = 1'b0;
            lock[i] = 1'b0;
        end
    endtask

    task automatic add_op(input int id, input logic r, input logic l, input logic [31:0] a,
                          input logic [31:0] w, input logic [1:0] s);
        ops[id][nops[id]] = '{r, l, a, w, s};
        nops[id]++;
    endtask

    task automatic expect_done(input int id, input logic r, input logic l, input logic [31:0] a,
                               input logic [31:0] w, input logic [1:0] s, input logic e);
        exp_q.push_back('{2'(id), r, l, e, a, w, use_fixed ? fixed_data : mix(a), s});
    endtask

    task automatic clear();
        for (int i = 0; i < 3; i++) begin
            nops[i] = 0;
            pos[i]  = 0;
        end
        req  = '0;
        lock = '0;
    endtask

    task automatic monitor();
        exp_t e;
        if (gap_chk && bus_req && !prev_req && seen_req) check("idle_gap", low_run, 1);
        if (bus_req) begin
            seen_req = 1'b1;
            low_run  = 0;
        end else low_run++;
        prev_req = bus_req;
        if (|(ack | err)) begin
            check("pulse_onehot", $countones(ack | err), 1);
            if (exp_q.size() == 0) check("unexpected_done", 32'(ack | err), 0);
            else begin
                e = exp_q.pop_front();
                check("done_id", 32'(ack | err), 1 << e.id);
                check("is_err", 32'(|err), 32'(e.err));
                check("bus_adr", last_adr, e.adr);
                check("bus_rw", 32'(last_rw), 32'(e.rw));
                check("bus_size", 32'(last_sz), 32'(e.sz));
                check("bus_lock", 32'(last_lock), 32'(e.lk));
                if (!e.rw) check("bus_wdata", last_wd, e.wd);
                if (e.rw && !e.err) check("data_o", data_o, e.rd);
            end
        end
    endtask

    task automatic responder();
        if (bus_rdy || bus_err) begin
            bus_rdy = 1'b0;
            bus_err = 1'b0;
            bus_cnt = 0;
        end else if (bus_req) begin
            bus_cnt++;
            if (bus_cnt > wait_n) begin
                last_adr    = bus_adr;
                last_rw     = bus_rw;
                last_wd     = bus_data_out;
                last_sz     = bus_size;
                last_lock   = bus_lock;
                bus_data_in = use_fixed ? fixed_data : mix(bus_adr);
                if (err_pend) begin
                    bus_err  = 1'b1;
                    err_pend = 1'b0;
                end else bus_rdy = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
        responder();
        for (int i = 0; i < 3; i++) if (ack[i] || err[i]) begin
            pos[i]++;
            load(i);
        end
    endtask

    task automatic run(input int budget);
        int c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            step();
            c++;
        end
        check("done_in_budget", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) step();
    endtask

    initial begin
        int n_ack;
        int ord [9] = '{0, 1, 0, 1, 2, 0, 1, 0, 1};
        int cnt [3] = '{0, 0, 0};
        reset = 1'b1; req = '0; rw = '0; lock = '0; adr_i = '0; data_i = '0; size_i = '0;
        bus_data_in = '0; bus_rdy = 1'b0; bus_err = 1'b0;
        clear();
        step();
        step();
        check("rst_ack_err", 32'(ack | err), 0);
        check("rst_bus_req", 32'(bus_req), 0);
        check("rst_bus_lock", 32'(bus_lock), 0);
        check("rst_gnt", 32'(gnt_id), 0);
        check("rst_data_o", data_o, 0);
        check("rst_bus_regs", bus_adr | bus_data_out | 32'(bus_size) | 32'(bus_rw), 0);
        reset = 1'b0;
        step();

        // single read with two wait cycles
        wait_n = 2; use_fixed = 1'b1; fixed_data = 32'hDEADBEEF;
        add_op(2, 1, 0, 32'h0000_1000, 0, 2'b10);
        expect_done(2, 1, 0, 32'h0000_1000, 0, 2'b10, 0);
        load(2);
        step();
        check("rd_req_c1", 32'(bus_req), 1);
        check("rd_gnt_c1", 32'(gnt_id), 2);
        check("rd_adr_c1", bus_adr, 32'h0000_1000);
        check("rd_rw_c1", 32'(bus_rw), 1);
        step();
        check("rd_req_c2", 32'(bus_req), 1);
        step();
        check("rd_req_c3", 32'(bus_req), 1);
        step();
        check("rd_req_c4", 32'(bus_req), 0);
        check("rd_ack_c4", 32'(ack), 32'b100);
        check("rd_data_c4", data_o, 32'hDEADBEEF);
        run(10);
        use_fixed = 1'b0;
        clear();

        // bus responses outside a bus cycle are ignored
        bus_rdy = 1'b1; bus_data_in = 32'h1234_5678;
        step();
        check("stray_rdy_pulse", 32'(ack | err), 0);
        step();
        check("stray_rdy_pulse2", 32'(ack | err), 0);
        check("stray_rdy_data", data_o, 32'hDEADBEEF);
        check("stray_rdy_req", 32'(bus_req), 0);

        // fixed priority, one wait state, mandatory idle cycle between grants
        wait_n = 1; gap_chk = 1'b1; seen_req = 1'b0;
        add_op(0, 0, 0, 32'h0000_0100, 32'hA0A0_0001, 2'b00);
        add_op(1, 1, 0, 32'h0000_0204, 0, 2'b01);
        add_op(2, 0, 0, 32'h0000_0308, 32'hC0C0_0003, 2'b11);
        expect_done(0, 0, 0, 32'h0000_0100, 32'hA0A0_0001, 2'b00, 0);
        expect_done(1, 1, 0, 32'h0000_0204, 0, 2'b01, 0);
        expect_done(2, 0, 0, 32'h0000_0308, 32'hC0C0_0003, 2'b11, 0);
        for (int i = 0; i < 3; i++) load(i);
        run(60);
        clear();

        // starvation guard: 0 and 1 keep requesting, 2 forced after four grants
        wait_n = 0; seen_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            add_op(0, 0, 0, adr_of(0, k), ~adr_of(0, k), 2'b00);
            add_op(1, 1, 0, adr_of(1, k), 0, 2'b10);
        end
        add_op(2, 1, 0, adr_of(2, 0), 0, 2'b00);
        foreach (ord[j]) begin
            expect_done(ord[j], ord[j] != 0, 0, adr_of(ord[j], cnt[ord[j]]), ~adr_of(ord[j], cnt[ord[j]]),
                        ord[j] == 1 ? 2'b10 : 2'b00, 0);
            cnt[ord[j]]++;
        end
        for (int i = 0; i < 3; i++) load(i);
        run(80);
        gap_chk = 1'b0;
        clear();

        // TAS: locked read then write by requester 1 while requester 0 waits
        wait_n = 1;
        add_op(1, 1, 1, 32'h0000_5000, 0, 2'b01);
        add_op(1, 0, 0, 32'h0000_5000, 32'h0000_0080, 2'b01);
        add_op(0, 1, 0, 32'h0000_6000, 0, 2'b00);
        expect_done(1, 1, 1, 32'h0000_5000, 0, 2'b01, 0);
        expect_done(1, 0, 1, 32'h0000_5000, 32'h0000_0080, 2'b01, 0);
        expect_done(0, 1, 0, 32'h0000_6000, 0, 2'b00, 0);
        load(1);
        step();
        check("tas_first_lock", 32'(bus_lock), 1);
        load(0);
        n_ack = 0;
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            step();
            if (ack[1]) n_ack++;
            else if (n_ack == 1) check("tas_lock_held", 32'(bus_lock), 1);
            if (bus_req && gnt_id == 2'd0) check("tas_idx0_after", n_ack, 2);
        end
        run(5);
        clear();

        // bus error on the locked read of a CAS
        wait_n = 1; err_pend = 1'b1;
        add_op(1, 1, 1, 32'h0000_7000, 0, 2'b00);
        add_op(0, 0, 0, 32'h0000_7100, 32'h5555_AAAA, 2'b10);
        expect_done(1, 1, 1, 32'h0000_7000, 0, 2'b00, 1);
        expect_done(0, 0, 0, 32'h0000_7100, 32'h5555_AAAA, 2'b10, 0);
        load(1);
        step();
        load(0);
        for (int c = 0; c < 30; c++) begin
            step();
            if (err != 3'b000) break;
        end
        check("cas_err", 32'(err), 32'b010);
        check("cas_err_no_ack", 32'(ack), 0);
        check("cas_err_unlock", 32'(bus_lock), 0);
        check("cas_err_idle", 32'(bus_req), 0);
        step();
        check("cas_next_req", 32'(bus_req), 1);
        check("cas_next_gnt", 32'(gnt_id), 0);
        check("cas_next_lock", 32'(bus_lock), 0);
        run(20);
        clear();

        // reset in the middle of a locked bus cycle
        wait_n = 20;
        add_op(1, 1, 1, 32'h0000_8000, 0, 2'b00);
        load(1);
        step();
        step();
        check("rst_mid_pre_lock", 32'(bus_lock), 1);
        reset = 1'b1;
        clear();
        step();
        reset = 1'b0;
        bus_cnt = 0;
        check("rst_mid_req", 32'(bus_req), 0);
        check("rst_mid_lock", 32'(bus_lock), 0);
        check("rst_mid_pulse", 32'(ack | err), 0);
        check("rst_mid_gnt", 32'(gnt_id), 0);
        check("rst_mid_adr", bus_adr, 0);
        step();
        check("rst_mid_after", 32'(ack | err | {2'b00, bus_req}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
